// File: rtl/line_buffer_3row_if.sv
// Pixel stream in, vertically aligned column triple out, for the 3-row line buffer.
// The source side takes the master modport; the line buffer takes the slave modport.
interface line_buffer_3row_if #(
  parameter int BIT_DEPTH = 8,
  parameter int IMG_WIDTH = 28
);
  logic                         pix_valid;
  logic [BIT_DEPTH-1:0]         pix_in;
  logic [BIT_DEPTH-1:0]         out1;
  logic [BIT_DEPTH-1:0]         out2;
  logic [BIT_DEPTH-1:0]         out3;
  logic                         out_valid;
  logic                         win_valid;
  logic [$clog2(IMG_WIDTH)-1:0] col_idx;
  logic                         frame_done;

  modport master (
    output pix_valid, pix_in,
    input  out1, out2, out3, out_valid, win_valid, col_idx, frame_done
  );

  modport slave (
    input  pix_valid, pix_in,
    output out1, out2, out3, out_valid, win_valid, col_idx, frame_done
  );
endinterface

// File: rtl/line_buffer_3row.sv
// Two-row line buffer emitting column triples (rows r-2, r-1, r) one cycle after each
// accepted pixel; one pixel per cycle, no back-pressure, gaps simply hold the outputs.
module line_buffer_3row #(
  parameter int BIT_DEPTH  = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input logic               clk,
  input logic               rst,
  line_buffer_3row_if.slave bus
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [BIT_DEPTH-1:0] lb_top [IMG_WIDTH];
  logic [BIT_DEPTH-1:0] lb_mid [IMG_WIDTH];
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;

  // Row gating guarantees stale contents are never emitted, so the memories have no reset.
  always_ff @(posedge clk) begin
    if (!rst && bus.pix_valid) begin
      lb_top[col] <= lb_mid[col];
      lb_mid[col] <= bus.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col            <= '0;
      row            <= '0;
      bus.out1       <= '0;
      bus.out2       <= '0;
      bus.out3       <= '0;
      bus.col_idx    <= '0;
      bus.out_valid  <= 1'b0;
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.out_valid  <= 1'b0;
      bus.win_valid  <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.pix_valid) begin
        bus.out1       <= lb_top[col];
        bus.out2       <= lb_mid[col];
        bus.out3       <= bus.pix_in;
        bus.col_idx    <= col;
        bus.out_valid  <= (row >= RW'(2));
        bus.win_valid  <= (row >= RW'(2)) && (col >= CW'(2));
        bus.frame_done <= (row == ROW_LAST) && (col == COL_LAST);
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_line_buffer_3row.sv
// Directed and randomized checks of line_buffer_3row on a 4x4 frame against a frame-array model.
module tb_line_buffer_3row;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_buffer_3row_if #(.BIT_DEPTH(8), .IMG_WIDTH(W)) bus ();
  line_buffer_3row #(.BIT_DEPTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for the downstream 3x3 window: shifts in a column on every out_valid.
  logic [7:0] win [3][3];
  always @(posedge clk) begin
    if (bus.out_valid) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= bus.out1;
      win[1][2] <= bus.out2;
      win[2][2] <= bus.out3;
    end
  end

  int checks = 0;
  int passes = 0;

  // Reference model: pixels of the current frame by raster index.
  logic [7:0] frame [N];
  int         k = 0;
  logic [7:0] e_o1, e_o2, e_o3;
  int         e_col;
  bit         e_ov, e_wv, e_fd;
  bit         known12;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d (check %0d)", tag, obs, exp, checks);
  endtask

  task automatic step(input bit v, input logic [7:0] p, input bit r);
    int row, col;
    bus.pix_valid = v;
    bus.pix_in    = p;
    rst           = r;
    @(posedge clk);
    #1;
    if (r) begin
      k = 0;
      e_o1 = 0; e_o2 = 0; e_o3 = 0; e_col = 0;
      e_ov = 0; e_wv = 0; e_fd = 0;
      known12 = 1;
    end else if (v) begin
      row = k / W;
      col = k % W;
      frame[k] = p;
      e_o3  = p;
      e_col = col;
      e_ov  = (row >= 2);
      e_wv  = (row >= 2) && (col >= 2);
      e_fd  = (k == N - 1);
      known12 = (row >= 2);
      if (row >= 2) begin
        e_o1 = frame[k - 2 * W];
        e_o2 = frame[k - W];
      end
      k = (k + 1) % N;
    end else begin
      e_ov = 0; e_wv = 0; e_fd = 0;
    end
    chk("out_valid", 32'(bus.out_valid), 32'(e_ov));
    chk("win_valid", 32'(bus.win_valid), 32'(e_wv));
    chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    chk("col_idx", 32'(bus.col_idx), 32'(e_col));
    chk("out3", 32'(bus.out3), 32'(e_o3));
    if (known12) begin
      chk("out1", 32'(bus.out1), 32'(e_o1));
      chk("out2", 32'(bus.out2), 32'(e_o2));
    end
  endtask

  task automatic send_frame(input int base, input int max_gap);
    for (int i = 0; i < N; i++) begin
      step(1'b1, 8'(base + i), 1'b0);
      if (max_gap > 0) begin
        int g;
        g = (i < 6) ? 1 : int'($urandom_range(0, max_gap));
        for (int j = 0; j < g; j++) step(1'b0, 8'($urandom), 1'b0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_in    = '0;
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);

    // Continuous frame, plus the window contents once pixel 10's triple is written.
    for (int i = 0; i < N; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 11) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            chk($sformatf("win[%0d][%0d]", r, c), 32'(win[r][c]), 32'(W * r + c));
      end
    end
    step(1'b0, 8'd0, 1'b0);

    // Gapped frame.
    send_frame(0, 3);

    // Back-to-back frames A then B.
    send_frame(0, 0);
    send_frame(100, 0);
    step(1'b0, 8'd0, 1'b0);

    // Reset mid-frame after pixel 9, then restream.
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'd0, 1'b1);
    send_frame(0, 0);

    // Reset together with a valid pixel.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'd55, 1'b1);
    step(1'b1, 8'd0, 1'b0);
    chk("col_idx_after_rst_valid", 32'(bus.col_idx), 32'd0);
    for (int i = 1; i < N; i++) step(1'b1, 8'(i), 1'b0);

    // Random pixels with random valid over several frames.
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 9) < 7), 8'($urandom), 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/line_buffer_3row.md
# line_buffer_3row

Streaming 3-row line buffer that turns a raster-order pixel stream into three vertically aligned pixels per cycle: the same column from rows r-2, r-1 and r. It sits directly upstream of the 3x3 window shift register in the convolution datapath. Its three row outputs drive the window's `in1`/`in2`/`in3` (top, middle, bottom), and its `out_valid` drives the window's `wr_en`. It stores two image rows internally and tracks the column and row position within the frame.

## Interface
- `BIT_DEPTH`, 8: pixel width in bits.
- `IMG_WIDTH`, 28: pixels per row; must be ≥ 3.
- `IMG_HEIGHT`, 28: rows per frame; must be ≥ 3.

Ports:
- `clk`  input  1  sole clock; all logic on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `pix_valid`  input  1  `pix_in` carries a valid pixel this cycle.
- `pix_in`  input  BIT_DEPTH  pixel in raster order (row-major, column 0 first).
- `out1`  output  BIT_DEPTH  pixel at the current column, row r-2 (top).
- `out2`  output  BIT_DEPTH  pixel at the current column, row r-1 (middle).
- `out3`  output  BIT_DEPTH  pixel at the current column, row r (bottom, the incoming pixel).
- `out_valid`  output  1  `out1..out3` are a valid column triple; connects to the window's `wr_en`.
- `win_valid`  output  1  asserted with `out_valid` when the current column is ≥ 2, meaning the downstream 3x3 window becomes complete on this write.
- `col_idx`  output  $clog2(IMG_WIDTH)  column of the triple currently on `out1..out3`.
- `frame_done`  output  1  one-cycle pulse accompanying the last pixel of the frame.

## Operation
- **Storage.** Two row memories, `lb_top` and `lb_mid`, each with `IMG_WIDTH` × `BIT_DEPTH` entries. Both are indexed by the column counter `col`. The row counter is `row`.
- **Accepted pixel.** On each cycle with `pix_valid`=1:
  - Register `out1`←`lb_top[col]`, `out2`←`lb_mid[col]`, `out3`←`pix_in`, `col_idx`←`col`.
  - Write `lb_top[col]`←`lb_mid[col]` (old value) and `lb_mid[col]`←`pix_in`. This read-before-write happens in the same cycle.
  - Set `out_valid`←(`row` ≥ 2).
  - Set `win_valid`←(`row` ≥ 2 && `col` ≥ 2).
  - Set `frame_done`←(`row`==IMG_HEIGHT-1 && `col`==IMG_WIDTH-1).
  - Advance the counters. If `col`==IMG_WIDTH-1, then `col`←0 and `row` increments, or wraps to 0 if `row`==IMG_HEIGHT-1. Otherwise `col` increments.
- **Cycle without a pixel.** When `pix_valid`=0, `out_valid`, `win_valid` and `frame_done` are 0 next cycle. `out1..out3` and `col_idx` hold, and the counters and memories are unchanged. Input gaps of any length are legal at any position.
- **Row gating.** Rows 0 and 1 of each frame only fill the buffers, so `out_valid` stays 0 for the first 2×IMG_WIDTH accepted pixels of every frame.
- **Frame boundaries.**
  - A new frame starts immediately after `frame_done`, with no idle cycle required.
  - Buffer contents carried over from the previous frame are never emitted. Rows 0 and 1 of the new frame overwrite every entry before `row` reaches 2.
- **Reset.**
  - State on reset: `col`=0, `row`=0, all outputs 0.
  - Memories are not cleared; the row gating above makes clearing unnecessary.
  - Reset mid-frame abandons the current frame. The next accepted pixel is row 0, column 0.
- **Counter widths.** `col` is $clog2(IMG_WIDTH) bits and `row` is $clog2(IMG_HEIGHT) bits. Wrap is explicit by compare, never by overflow, so non-power-of-two sizes are exact.

## Timing
- **Latency.** Exactly 1 cycle from a pixel being accepted to its column triple on `out1..out3` with `out_valid`.
- **Throughput.** One pixel per cycle sustained; no back-pressure.
- **Flag alignment.** `out_valid`, `win_valid`, `frame_done` and `col_idx` are all registered and aligned to the same cycle as `out1..out3`.
- **Reset precedence.** `rst` overrides `pix_valid` in the same cycle; the pixel is dropped.
- **Memory implementation.** Register array or distributed RAM with combinational read. Block RAM is not allowed without adding a pipeline stage, which would violate the latency above.

## Test plan
All scenarios use IMG_WIDTH=4 and IMG_HEIGHT=4, with pixel value = 4·row + col.

- **Continuous frame.** Send pixels 0..15 on consecutive cycles. Required response:
  - `out_valid`=0 for the first 8 output cycles.
  - The pixel-8 output shows out1=0, out2=4, out3=8, col_idx=0, win_valid=0.
  - The pixel-10 output shows 2/6/10 with win_valid=1.
  - The pixel-15 output shows 7/11/15 with frame_done=1 (single cycle).
- **Gapped input.** Same frame with `pix_valid` toggled 1-0-1-0 and random 3-cycle gaps. Required response:
  - Identical triple sequence to the continuous case.
  - Outputs hold during gaps, with `out_valid`=0 on every gap cycle.
- **Back-to-back frames.** Frame A (values 0..15), then frame B (values 100+index) with no gap. Required response:
  - No `out_valid` during B rows 0–1.
  - The first B triple is 100/104/108; no frame-A value ever appears.
- **Reset mid-frame.** Assert `rst` for 1 cycle after pixel 9. Required response:
  - The cycle after reset shows all outputs 0.
  - Restreaming 0..15 gives the exact continuous-case sequence.
- **Reset with valid.** Assert `rst` and `pix_valid` together. Required response: the pixel is ignored and `col_idx` of the next accepted pixel is 0.
- **Downstream integration.** Connect to the 3x3 window (out1..3 to in1..3, out_valid to wr_en) and stream the frame. Required response: on the cycle after `win_valid`=1 for pixel 10, the window contents are rows {0,1,2}, columns {0,1,2}.
